// File: rtl/inverter_pkg.sv
// ----------------------------------------------------------------------------
// inverter_pkg
// Shared definitions for the inverter arbiter slice: default parameter values,
// the arbiter state encoding and a small helper that maps a source index to
// its grant state.
// ----------------------------------------------------------------------------
package inverter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_CNT_WIDTH  = 16;
    localparam int NUM_SOURCES        = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    // Grant state that serves source 'src'.
    function automatic arb_state_t grant_state(input logic src);
        return src ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// ----------------------------------------------------------------------------
// axis_reg_slice
// Single-entry AXI-Stream register stage carrying data, tlast and a one-bit
// source id. A beat accepted on the input side appears on the output the next
// cycle and is held stable until out_ready. A pop and a push in the same cycle
// replace the contents without a bubble.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (clears valid and contents)
//   in_data/in_last/in_id/in_valid : upstream beat
//   in_ready   : register empty or being drained this cycle
//   out_data/out_last/out_id/out_valid : registered beat
//   out_ready  : downstream accept
// ----------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_id,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_id,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;
    logic                  id_reg;
    logic                  valid_reg;

    assign in_ready = !valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            last_reg  <= 1'b0;
            id_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            data_reg  <= in_data;
            last_reg  <= in_last;
            id_reg    <= in_id;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            // Drained with nothing new: contents are left as-is, only valid drops.
            valid_reg <= 1'b0;
        end
    end

    assign out_data  = data_reg;
    assign out_last  = last_reg;
    assign out_id    = id_reg;
    assign out_valid = valid_reg;

endmodule

// File: rtl/inverter_arbiter.sv
// ----------------------------------------------------------------------------
// inverter_arbiter
// Packet-granular two-way arbiter feeding a shared byte-inverter datapath.
// Whole packets from S0 or S1 are forwarded through one register stage; beats
// of different packets are never interleaved. Contention in IDLE is resolved
// by a round-robin pointer that flips to the other source whenever a packet
// completes. A per-source counter tracks forwarded packets (wrapping).
//
// Ports
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   S0_AXIS_*, S1_AXIS_*  : requester streams (TDATA/TVALID/TLAST in, TREADY out)
//   M_AXIS_*              : output stream (TDATA/TVALID/TLAST/TID out, TREADY in)
//   PKT_COUNT_0/1         : packets accepted per source
//   BUSY                  : FSM not idle or output register occupied
// ----------------------------------------------------------------------------
module inverter_arbiter
    import inverter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
    input  logic                  S0_AXIS_TVALID,
    input  logic                  S0_AXIS_TLAST,
    output logic                  S0_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
    input  logic                  S1_AXIS_TVALID,
    input  logic                  S1_AXIS_TLAST,
    output logic                  S1_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TID,
    input  logic                  M_AXIS_TREADY,
    output logic [CNT_WIDTH-1:0]  PKT_COUNT_0,
    output logic [CNT_WIDTH-1:0]  PKT_COUNT_1,
    output logic                  BUSY
);

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is aligned to
    // CLK so no flop sees RESET_N rise close to an active edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    // ------------------------------------------------------------------
    // Source bundling so per-source logic can be generated.
    // ------------------------------------------------------------------
    logic [NUM_SOURCES-1:0] s_valid;
    logic [NUM_SOURCES-1:0] s_last;
    logic [NUM_SOURCES-1:0] s_ready;
    logic [NUM_SOURCES-1:0] pkt_done;
    logic [DATA_WIDTH-1:0]  s_data [NUM_SOURCES];

    assign s_valid   = {S1_AXIS_TVALID, S0_AXIS_TVALID};
    assign s_last    = {S1_AXIS_TLAST, S0_AXIS_TLAST};
    assign s_data[0] = S0_AXIS_TDATA;
    assign s_data[1] = S1_AXIS_TDATA;

    assign S0_AXIS_TREADY = s_ready[0];
    assign S1_AXIS_TREADY = s_ready[1];

    // ------------------------------------------------------------------
    // Arbiter FSM: state register / next-state / outputs.
    // ------------------------------------------------------------------
    arb_state_t state_reg, state_next;
    logic       rr_reg, rr_next;

    logic                  slice_in_ready;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_last;
    logic                  push_id;

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg <= ST_IDLE;
            rr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (s_valid[0] && s_valid[1]) begin
                    state_next = grant_state(rr_reg);
                end else if (s_valid[0]) begin
                    state_next = ST_GRANT0;
                end else if (s_valid[1]) begin
                    state_next = ST_GRANT1;
                end
            end
            // A grant is only released by an accepted TLAST beat, so a
            // stalled source keeps the datapath indefinitely.
            ST_GRANT0: begin
                if (pkt_done[0]) begin
                    state_next = ST_IDLE;
                    rr_next    = 1'b1;
                end
            end
            ST_GRANT1: begin
                if (pkt_done[1]) begin
                    state_next = ST_IDLE;
                    rr_next    = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = '0;
        push_valid = 1'b0;
        push_data  = s_data[0];
        push_last  = s_last[0];
        push_id    = 1'b0;
        case (state_reg)
            ST_GRANT0: begin
                s_ready[0] = slice_in_ready;
                push_valid = s_valid[0];
            end
            ST_GRANT1: begin
                s_ready[1] = slice_in_ready;
                push_valid = s_valid[1];
                push_data  = s_data[1];
                push_last  = s_last[1];
                push_id    = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-source packet completion and wrapping packet counters.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] pkt_count [NUM_SOURCES];

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            logic [CNT_WIDTH-1:0] cnt_reg;

            assign pkt_done[gi] = s_valid[gi] && s_ready[gi] && s_last[gi];

            always_ff @(posedge CLK or negedge rst_n_int) begin
                if (!rst_n_int) begin
                    cnt_reg <= '0;
                end else if (pkt_done[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign pkt_count[gi] = cnt_reg;
        end
    endgenerate

    assign PKT_COUNT_0 = pkt_count[0];
    assign PKT_COUNT_1 = pkt_count[1];

    // ------------------------------------------------------------------
    // Output register stage.
    // ------------------------------------------------------------------
    axis_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_slice (
        .clk       (CLK),
        .rst_n     (rst_n_int),
        .in_data   (push_data),
        .in_last   (push_last),
        .in_id     (push_id),
        .in_valid  (push_valid),
        .in_ready  (slice_in_ready),
        .out_data  (M_AXIS_TDATA),
        .out_last  (M_AXIS_TLAST),
        .out_id    (M_AXIS_TID),
        .out_valid (M_AXIS_TVALID),
        .out_ready (M_AXIS_TREADY)
    );

    assign BUSY = (state_reg != ST_IDLE) || M_AXIS_TVALID;

endmodule

// File: tb/tb_inverter_arbiter.sv
// ----------------------------------------------------------------------------
// tb_inverter_arbiter
// Drivers push every issued beat into a per-source expected queue; an
// independent monitor pops the queue selected by M_AXIS_TID whenever a beat is
// handed off downstream. Packet counts are modelled as packets-issued modulo
// 2^CNT_WIDTH. Directed scenarios additionally check ordering and timing from
// the logged output beats.
// ----------------------------------------------------------------------------
module tb_inverter_arbiter;

    localparam int DW = 64;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          CLK;
    logic          RESET_N;
    logic [DW-1:0] S0_AXIS_TDATA, S1_AXIS_TDATA, M_AXIS_TDATA;
    logic          S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TREADY;
    logic          S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY;
    logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TID, M_AXIS_TREADY;
    logic [CW-1:0] PKT_COUNT_0, PKT_COUNT_1;
    logic          BUSY;

    inverter_arbiter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .S0_AXIS_TDATA  (S0_AXIS_TDATA),
        .S0_AXIS_TVALID (S0_AXIS_TVALID),
        .S0_AXIS_TLAST  (S0_AXIS_TLAST),
        .S0_AXIS_TREADY (S0_AXIS_TREADY),
        .S1_AXIS_TDATA  (S1_AXIS_TDATA),
        .S1_AXIS_TVALID (S1_AXIS_TVALID),
        .S1_AXIS_TLAST  (S1_AXIS_TLAST),
        .S1_AXIS_TREADY (S1_AXIS_TREADY),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .M_AXIS_TID     (M_AXIS_TID),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .PKT_COUNT_0    (PKT_COUNT_0),
        .PKT_COUNT_1    (PKT_COUNT_1),
        .BUSY           (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    exp_cnt [2];
    bit    mon_en  = 0;
    int    bp_mode = 0;   // 0: always ready, 1: random, 2: driven by main
    beat_t q0 [$];
    beat_t q1 [$];
    int    out_tid [$];
    int    out_cyc [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input int src, input logic v, input logic [DW-1:0] d, input logic l);
        if (src == 0) begin
            S0_AXIS_TVALID = v; S0_AXIS_TDATA = d; S0_AXIS_TLAST = l;
        end else begin
            S1_AXIS_TVALID = v; S1_AXIS_TDATA = d; S1_AXIS_TLAST = l;
        end
    endtask

    // Sends one packet from 'src'. Called just after a falling edge; beats
    // are changed on falling edges and the handshake is sampled just before
    // the rising edge.
    task automatic send_pkt(input int src, input int nbeats, input int data_mode,
                            input int gap_beat, input int gap_len, input int rand_gap);
        for (int b = 0; b < nbeats; b++) begin
            int            g;
            int            waited;
            bit            acc;
            logic [DW-1:0] d;
            beat_t         bt;
            g = (b == gap_beat) ? gap_len : ((rand_gap > 0) ? int'($urandom_range(0, rand_gap)) : 0);
            if (g > 0) begin
                drive(src, 1'b0, '0, 1'b0);
                repeat (g) @(negedge CLK);
            end
            d = (data_mode == 1) ? DW'(b + 1) : {$urandom, $urandom};
            drive(src, 1'b1, d, (b == nbeats - 1));
            bt.data = d;
            bt.last = (b == nbeats - 1);
            if (src == 0) q0.push_back(bt); else q1.push_back(bt);
            acc = 0;
            waited = 0;
            while (!acc && waited < 500) begin
                #4;
                acc = (src == 0) ? S0_AXIS_TREADY : S1_AXIS_TREADY;
                @(negedge CLK);
                waited++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL accept_timeout src=%0d actual=no_handshake required=handshake", src);
                drive(src, 1'b0, '0, 1'b0);
                return;
            end
        end
        drive(src, 1'b0, '0, 1'b0);
        exp_cnt[src] = (exp_cnt[src] + 1) % (1 << CW);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0 || M_AXIS_TVALID) && w < 400) begin
            @(negedge CLK);
            w++;
        end
        chk("drain_pending", 64'(q0.size() + q1.size()), 0);
    endtask

    task automatic clear_log();
        out_tid.delete();
        out_cyc.delete();
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_cnt0"}, 64'(PKT_COUNT_0), 64'(exp_cnt[0]));
        chk({tag, "_cnt1"}, 64'(PKT_COUNT_1), 64'(exp_cnt[1]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 64'(M_AXIS_TVALID), 0);
        chk({tag, "_m_tlast"},  64'(M_AXIS_TLAST), 0);
        chk({tag, "_m_tid"},    64'(M_AXIS_TID), 0);
        chk({tag, "_m_tdata"},  M_AXIS_TDATA, 0);
        chk({tag, "_cnt0"},     64'(PKT_COUNT_0), 0);
        chk({tag, "_cnt1"},     64'(PKT_COUNT_1), 0);
        chk({tag, "_s0_ready"}, 64'(S0_AXIS_TREADY), 0);
        chk({tag, "_s1_ready"}, 64'(S1_AXIS_TREADY), 0);
        chk({tag, "_busy"},     64'(BUSY), 0);
    endtask

    // Downstream ready generator.
    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(negedge CLK);
            if (bp_mode == 0) M_AXIS_TREADY = 1'b1;
            else if (bp_mode == 1) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit            in_pkt;
        bit            cur_tid;
        bit            stall;
        logic [DW-1:0] hd;
        logic          hl, ht;
        beat_t         e;
        in_pkt = 0; cur_tid = 0; stall = 0; hd = '0; hl = 0; ht = 0;
        forever begin
            @(negedge CLK);
            #4;
            if (!mon_en) begin
                in_pkt = 0;
                stall  = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(M_AXIS_TVALID), 1);
                    chk("hold_data", M_AXIS_TDATA, hd);
                    chk("hold_last_tid", {62'd0, M_AXIS_TLAST, M_AXIS_TID}, {62'd0, hl, ht});
                end
                if (M_AXIS_TVALID && !M_AXIS_TREADY) begin
                    chk("bp_src_ready", {62'd0, S1_AXIS_TREADY, S0_AXIS_TREADY}, 0);
                    stall = 1;
                    hd = M_AXIS_TDATA; hl = M_AXIS_TLAST; ht = M_AXIS_TID;
                end else begin
                    stall = 0;
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (in_pkt) chk("no_interleave", 64'(M_AXIS_TID), 64'(cur_tid));
                    if ((M_AXIS_TID ? q1.size() : q0.size()) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat tid=%0d actual=%0h required=none", M_AXIS_TID, M_AXIS_TDATA);
                    end else begin
                        e = M_AXIS_TID ? q1.pop_front() : q0.pop_front();
                        chk("beat_data", M_AXIS_TDATA, e.data);
                        chk("beat_last", 64'(M_AXIS_TLAST), 64'(e.last));
                    end
                    out_tid.push_back(int'(M_AXIS_TID));
                    out_cyc.push_back(cyc);
                    in_pkt  = !M_AXIS_TLAST;
                    cur_tid = M_AXIS_TID;
                end
            end
        end
    end

    // Main sequence.
    initial begin
        int t0;
        int viol;
        bit s1_done;
        bit acc;
        int w;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        mon_en = 1;

        // Contention straight after reset: S0 first, one bubble, then S1.
        clear_log();
        t0 = cyc;
        fork
            send_pkt(0, 3, 1, -1, 0, 0);
            send_pkt(1, 3, 1, -1, 0, 0);
        join
        drain();
        chk("rr_log_size", 64'(out_tid.size()), 6);
        if (out_tid.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("rr_order", 64'(out_tid[k]), (k < 3) ? 0 : 1);
            chk("rr_first_cycle", 64'(out_cyc[0]), 64'(t0 + 2));
            chk("rr_bubble", 64'(out_cyc[3] - out_cyc[2]), 2);
        end
        chk_counts("rr");

        // Pointer returned to S0 after S1 completed.
        clear_log();
        fork
            send_pkt(0, 2, 0, -1, 0, 0);
            send_pkt(1, 2, 0, -1, 0, 0);
        join
        drain();
        chk("rr_again_first", (out_tid.size() > 0) ? 64'(out_tid[0]) : 64'hdead, 0);
        chk_counts("rr_again");

        // S0-only 4-beat packet: beats at cycles 2..5 after TVALID.
        clear_log();
        t0 = cyc;
        send_pkt(0, 4, 1, -1, 0, 0);
        drain();
        chk("lat_log_size", 64'(out_tid.size()), 4);
        if (out_tid.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("lat_cycle", 64'(out_cyc[k]), 64'(t0 + 2 + k));
                chk("lat_tid", 64'(out_tid[k]), 0);
            end
        end
        chk_counts("lat");
        chk("idle_busy", 64'(BUSY), 0);

        // Downstream backpressure for 3 cycles mid-packet.
        bp_mode = 2;
        M_AXIS_TREADY = 1'b1;
        clear_log();
        fork
            send_pkt(0, 6, 0, -1, 0, 0);
            begin
                repeat (3) @(negedge CLK);
                M_AXIS_TREADY = 1'b0;
                repeat (3) @(negedge CLK);
                M_AXIS_TREADY = 1'b1;
            end
        join
        drain();
        bp_mode = 0;
        chk("bp_beats", 64'(out_tid.size()), 6);
        chk_counts("bp");

        // S1 stalls 5 cycles mid-packet while S0 waits.
        clear_log();
        viol = 0;
        s1_done = 0;
        fork
            begin
                send_pkt(1, 4, 1, 2, 5, 0);
                s1_done = 1;
            end
            begin
                repeat (2) @(negedge CLK);
                send_pkt(0, 2, 1, -1, 0, 0);
            end
            begin
                for (int i = 0; i < 200 && !s1_done; i++) begin
                    #4;
                    if (S0_AXIS_TREADY) viol++;
                    @(negedge CLK);
                end
            end
        join
        drain();
        chk("gap_s0_ready_seen", 64'(viol), 0);
        chk("gap_log_size", 64'(out_tid.size()), 6);
        if (out_tid.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("gap_order", 64'(out_tid[k]), (k < 4) ? 1 : 0);
        end
        chk_counts("gap");

        // Reset while beat 2 of a 4-beat S1 packet is presented.
        mon_en = 0;
        drive(1, 1'b1, 64'hA1, 1'b0);
        acc = 0;
        w = 0;
        while (!acc && w < 50) begin
            #4;
            acc = S1_AXIS_TREADY;
            @(negedge CLK);
            w++;
        end
        chk("rst_beat1_accepted", 64'(acc), 1);
        drive(1, 1'b1, 64'hA2, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        drive(1, 1'b0, '0, 1'b0);
        q0.delete();
        q1.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        mon_en = 1;
        clear_log();
        send_pkt(0, 3, 0, -1, 0, 0);
        drain();
        chk("postrst_beats", 64'(out_tid.size()), 3);
        if (out_tid.size() == 3) chk("postrst_tid", 64'(out_tid[0] + out_tid[1] + out_tid[2]), 0);
        chk_counts("postrst");

        // Counter wrap: 17 single-beat packets on S1.
        for (int i = 0; i < 17; i++) send_pkt(1, 1, 0, -1, 0, 0);
        drain();
        chk_counts("wrap");

        // Randomised traffic from both sources with random backpressure.
        bp_mode = 1;
        fork
            for (int i = 0; i < 20; i++) send_pkt(0, $urandom_range(1, 5), 0, -1, 0, 2);
            for (int i = 0; i < 20; i++) send_pkt(1, $urandom_range(1, 5), 0, -1, 0, 2);
        join
        bp_mode = 0;
        drain();
        chk_counts("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inverter_arbiter.md
INVERTER_ARBITER -- requirements
Module: inverter_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 64, stream data width (multiple of 8).
REQ-002 Parameter: CNT_WIDTH, 16, width of per-source packet counters.
REQ-003 Port: CLK  input  1  single clock; all logic rising-edge.
REQ-004 Port: RESET_N  input  1  asynchronous active-low reset.
REQ-005 Port: S0_AXIS_TDATA/TVALID/TLAST  input  DATA_WIDTH/1/1  requester 0 stream; S0_AXIS_TREADY output 1.
REQ-006 Port: S1_AXIS_TDATA/TVALID/TLAST  input  DATA_WIDTH/1/1  requester 1 stream; S1_AXIS_TREADY output 1.
REQ-007 Port: M_AXIS_TDATA/TVALID/TLAST  output  DATA_WIDTH/1/1  stream to the shared byte-inverter datapath; M_AXIS_TREADY input 1.
REQ-008 Port: M_AXIS_TID  output  1  source index of the current output beat.
REQ-009 Port: PKT_COUNT_0, PKT_COUNT_1  output  CNT_WIDTH  packets forwarded per source.
REQ-010 Port: BUSY  output  1  high when state is not IDLE or the output register holds a beat.

Function
REQ-011 States: IDLE, GRANT0, GRANT1; packet-granular arbitration, never interleaving beats of two packets.
REQ-012 IDLE: only S0 valid -> GRANT0; only S1 valid -> GRANT1; both valid -> source selected by round-robin pointer RR; neither valid -> stay in IDLE.
REQ-013 GRANTx: stay until a beat with TLAST=1 is accepted from Sx; then go to IDLE next cycle and set RR to the other source.
REQ-014 RR holds its value while no packet completes.
REQ-015 Sx_AXIS_TREADY = (state==GRANTx) && (!M_AXIS_TVALID || M_AXIS_TREADY); TREADY is 0 in IDLE and for the ungranted source.
REQ-016 Output is a single register stage: an accepted beat appears on M_AXIS_* the next cycle with TID=x; data and TLAST pass unmodified.
REQ-017 M_AXIS_TVALID stays high and M_AXIS_TDATA/TLAST/TID stay stable until M_AXIS_TREADY=1.
REQ-018 Within a granted packet, 1 beat/cycle throughput while M_AXIS_TREADY=1; request-to-first-output latency is 2 cycles from IDLE.
REQ-019 Between packets there is exactly one IDLE bubble cycle with no upstream acceptance.
REQ-020 Simultaneous M-side pop and S-side push in one cycle replaces the register contents with no bubble.
REQ-021 PKT_COUNT_x increments by 1 when a TLAST beat from Sx is accepted upstream, and wraps from 2^CNT_WIDTH-1 to 0.
REQ-022 Single-beat packets (TVALID with TLAST on the first beat) are legal and complete the grant.
REQ-023 TVALID deasserting mid-packet on the granted source keeps the grant held; no timeout.

Reset
REQ-024 RESET_N low asynchronously forces: state=IDLE, RR=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TID=0, M_AXIS_TDATA=0, PKT_COUNT_0/1=0, both TREADY=0, BUSY=0.
REQ-025 Reset mid-packet discards the in-flight beat and partial packet; no recovery or resumption after release.
REQ-026 Reset release is synchronised to CLK so that the first post-reset state change is glitch-free.

Structure
REQ-027 State encoding (IDLE/GRANT0/GRANT1) and the default parameter values are defined in a shared package, inverter_pkg.
REQ-028 Output register stage is a sub-module, axis_reg_slice (data, tlast, tid, valid/ready); arbiter FSM and counters live in the top.

Verification
REQ-029 S0 only, 4-beat packet 0x01..0x04, M_AXIS_TREADY=1 -> beats on M at cycles 2..5 after TVALID, TID=0, TLAST on beat 4, PKT_COUNT_0=1.
REQ-030 S0 and S1 both valid from reset, 3 beats each -> S0 packet first (RR=0), one bubble, then S1 packet; RR ends at 0; counts 1/1.
REQ-031 Backpressure: M_AXIS_TREADY low for 3 cycles mid-packet -> M data held stable, granted TREADY=0, no beat lost or duplicated.
REQ-032 Counter wrap: CNT_WIDTH=4, 17 single-beat packets on S1 -> PKT_COUNT_1=1.
REQ-033 RESET_N low during beat 2 of a 4-beat S1 packet -> all outputs at reset values; after release, a new S0 packet is granted normally.
REQ-034 S1 TVALID gap of 5 cycles mid-packet while S0 is valid -> S0_AXIS_TREADY stays 0 until S1 TLAST is accepted.
